i2c_bus_conditioner: RTL and testbench

Physical/line layer between the scl/sda pads and the I2C slave engine on the slave board. It samples both open-drain lines into clk, filters glitches, and emits one-cycle SCL edge strobes and START/STOP/repeated-START events, plus a bus-busy flag with idle timeout. It also owns the open-drain pad drivers, so the slave engine works only on clean, synchronous strobes.

---
 rtl/i2c_bus_conditioner.sv | 128 ++++++++++++
 tb/tb_i2c_bus_conditioner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_conditioner.sv
// I2C line conditioner: synchronises and glitch-filters scl/sda, decodes edges and START/STOP,
// tracks bus-busy with idle timeout and owns the open-drain pads. Optional macro: I2C_CLK_STRETCH_EN.
module i2c_bus_conditioner #(
  parameter int FILTER_LEN   = 4,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  inout  wire  scl,
  inout  wire  sda,
  input  logic sda_drive_low,
  input  logic scl_hold,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rep_start,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam logic [3:0]  FL_MAX = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TO_MAX = 16'(IDLE_TIMEOUT - 1);

  logic        r_run;
  logic        r_sclMeta, r_sclSync, r_sdaMeta, r_sdaSync;
  logic        r_sclF, r_sdaF;
  logic [3:0]  r_sclCnt, r_sdaCnt;
  logic        r_sclRise, r_sclFall, r_sdaEdge;
  logic        r_startDet, r_stopDet;
  logic        r_busBusy;
  logic [15:0] r_idleCnt;

  logic w_sclDiff, w_sdaDiff, w_sclUpd, w_sdaUpd;
  logic w_edge, w_idle, w_timeout;

  // Pads stay released until the first clock after reset has been seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run     <= 1'b0;
      r_sclMeta <= 1'b1;
      r_sclSync <= 1'b1;
      r_sdaMeta <= 1'b1;
      r_sdaSync <= 1'b1;
    end else begin
      r_run     <= 1'b1;
      r_sclMeta <= scl;
      r_sclSync <= r_sclMeta;
      r_sdaMeta <= sda;
      r_sdaSync <= r_sdaMeta;
    end
  end

  assign w_sclDiff = (r_sclSync != r_sclF);
  assign w_sdaDiff = (r_sdaSync != r_sdaF);
  assign w_sclUpd  = w_sclDiff && (r_sclCnt == FL_MAX);
  assign w_sdaUpd  = w_sdaDiff && (r_sdaCnt == FL_MAX);

  // r_sclF still holds last cycle's filtered SCL here, so START/STOP classify on it
  // even when SCL falls on the same clock as the SDA change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclF     <= 1'b1;
      r_sdaF     <= 1'b1;
      r_sclCnt   <= 4'd0;
      r_sdaCnt   <= 4'd0;
      r_sclRise  <= 1'b0;
      r_sclFall  <= 1'b0;
      r_sdaEdge  <= 1'b0;
      r_startDet <= 1'b0;
      r_stopDet  <= 1'b0;
    end else begin
      r_sclCnt   <= (w_sclDiff && !w_sclUpd) ? r_sclCnt + 4'd1 : 4'd0;
      r_sdaCnt   <= (w_sdaDiff && !w_sdaUpd) ? r_sdaCnt + 4'd1 : 4'd0;
      if (w_sclUpd) r_sclF <= r_sclSync;
      if (w_sdaUpd) r_sdaF <= r_sdaSync;
      r_sclRise  <= w_sclUpd && r_sclSync;
      r_sclFall  <= w_sclUpd && !r_sclSync;
      r_sdaEdge  <= w_sdaUpd;
      r_startDet <= w_sdaUpd && !r_sdaSync && r_sclF;
      r_stopDet  <= w_sdaUpd && r_sdaSync && r_sclF;
    end
  end

  assign w_edge    = r_sclRise || r_sclFall || r_sdaEdge;
  assign w_idle    = r_busBusy && r_sclF && r_sdaF;
  assign w_timeout = w_idle && !w_edge && (r_idleCnt == TO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busBusy <= 1'b0;
      r_idleCnt <= 16'd0;
    end else begin
      if (r_startDet)
        r_busBusy <= 1'b1;
      else if (r_stopDet || w_timeout)
        r_busBusy <= 1'b0;
      if (!w_idle || w_edge)
        r_idleCnt <= 16'd0;
      else if (r_idleCnt != 16'hFFFF)
        r_idleCnt <= r_idleCnt + 16'd1;
    end
  end

  assign scl_f       = r_sclF;
  assign sda_f       = r_sdaF;
  assign scl_rise    = r_sclRise;
  assign scl_fall    = r_sclFall;
  assign start_det   = r_startDet;
  assign rep_start   = r_startDet && r_busBusy;
  assign stop_det    = r_stopDet;
  assign bus_busy    = r_busBusy;
  assign bus_timeout = w_timeout;

  // Open-drain only: a pad is either pulled low or left floating.
  assign sda = (r_run && sda_drive_low) ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  assign scl = (r_run && scl_hold) ? 1'b0 : 1'bz;
`else
  logic w_unusedSclHold;
  assign w_unusedSclHold = scl_hold;
  assign scl = 1'bz;
`endif

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Randomised scoreboard bench for i2c_bus_conditioner: a protocol-level model predicts
// filtered edges and bus events per cycle; a negedge monitor compares them with the DUT.
module tb_i2c_bus_conditioner;

  localparam int FL  = 4;
  localparam int TO  = 50;
  localparam int LAT = 2 + FL;

  localparam logic [7:0] EV_SDAR  = 8'h80;
  localparam logic [7:0] EV_SDAF  = 8'h40;
  localparam logic [7:0] EV_SCLR  = 8'h20;
  localparam logic [7:0] EV_SCLF  = 8'h10;
  localparam logic [7:0] EV_START = 8'h08;
  localparam logic [7:0] EV_REP   = 8'h04;
  localparam logic [7:0] EV_STOP  = 8'h02;
  localparam logic [7:0] EV_TO    = 8'h01;

  typedef struct {
    int         cyc;
    logic [7:0] ev;
  } expEv_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  wire  scl;
  wire  sda;
  logic tbSclLow = 1'b0;
  logic tbSdaLow = 1'b0;
  logic sda_drive_low = 1'b0;
  logic scl_hold = 1'b0;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, rep_start, stop_det, bus_busy, bus_timeout;

  pullup puScl (scl);
  pullup puSda (sda);
  assign scl = tbSclLow ? 1'b0 : 1'bz;
  assign sda = tbSdaLow ? 1'b0 : 1'bz;

  i2c_bus_conditioner #(.FILTER_LEN(FL), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .sda_drive_low(sda_drive_low), .scl_hold(scl_hold),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .rep_start(rep_start), .stop_det(stop_det),
    .bus_busy(bus_busy), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  expEv_t q[$];
  int checks = 0;
  int failures = 0;
  bit mScl = 1'b1;
  bit mSda = 1'b1;
  bit mBusy = 1'b0;
  bit expBusy = 1'b0;
  bit prevSdaF = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushEv(input int c, input logic [7:0] ev);
    expEv_t e;
    e.cyc = c;
    e.ev  = ev;
    q.push_back(e);
  endtask

  // Protocol rules: a clean pad change shows on the filtered line LAT cycles later;
  // an SDA change while SCL is high is START (fall) or STOP (rise); a busy bus left
  // with both lines high for TO cycles after its last edge times out.
  task automatic modelEdge(input bit isScl, input bit val, input int h);
    int x;
    logic [7:0] ev;
    x = cyc + LAT;
    if (isScl) begin
      ev = val ? EV_SCLR : EV_SCLF;
      mScl = val;
    end else begin
      ev = val ? EV_SDAR : EV_SDAF;
      if (mScl && !val) begin
        ev = ev | EV_START | (mBusy ? EV_REP : 8'h00);
        mBusy = 1'b1;
      end else if (mScl && val) begin
        ev = ev | EV_STOP;
        mBusy = 1'b0;
      end
      mSda = val;
    end
    pushEv(x, ev);
    if (mBusy && mScl && mSda && h > TO) begin
      pushEv(x + TO, EV_TO);
      mBusy = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit isScl, input bit val, input int h, input int g, input bit gScl);
    if (isScl) tbSclLow = !val;
    else tbSdaLow = !val;
    modelEdge(isScl, val, h);
    if (g > 0) begin
      waitCycles(5);
      if (gScl) tbSclLow = !tbSclLow;
      else tbSdaLow = !tbSdaLow;
      waitCycles(g);
      if (gScl) tbSclLow = !tbSclLow;
      else tbSdaLow = !tbSdaLow;
      waitCycles(h - 5 - g);
    end else begin
      waitCycles(h);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] obs;
    logic [7:0] expv;
    expEv_t e;
    if (!reset) begin
      expBusy  = 1'b0;
      prevSdaF = 1'b1;
    end else begin
      obs = {sda_f & !prevSdaF, !sda_f & prevSdaF, scl_rise, scl_fall,
             start_det, rep_start, stop_det, bus_timeout};
      prevSdaF = sda_f;
      expv = 8'h00;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_event cyc=%0d actual=none expected=%0h", q[0].cyc, q[0].ev);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        expv = e.ev;
      end
      if (obs != 8'h00 || expv != 8'h00)
        checkOutput($sformatf("events@%0d", cyc), 32'(obs), 32'(expv));
      checkOutput($sformatf("bus_busy@%0d", cyc), 32'(bus_busy), 32'(expBusy));
      if ((expv & EV_START) != 8'h00) expBusy = 1'b1;
      else if ((expv & (EV_STOP | EV_TO)) != 8'h00) expBusy = 1'b0;
    end
  end

  initial begin
    reset = 1'b0;
    sda_drive_low = 1'b1;
    scl_hold = 1'b1;
    waitCycles(3);
    checkOutput("rst_scl_f", 32'(scl_f), 32'd1);
    checkOutput("rst_sda_f", 32'(sda_f), 32'd1);
    checkOutput("rst_busy", 32'(bus_busy), 32'd0);
    checkOutput("rst_pulses", 32'({scl_rise, scl_fall, start_det, rep_start, stop_det, bus_timeout}), 32'd0);
    checkOutput("rst_sda_pad", 32'(sda), 32'd1);
    checkOutput("rst_scl_pad", 32'(scl), 32'd1);
    sda_drive_low = 1'b0;
    scl_hold = 1'b0;
    reset = 1'b1;
    waitCycles(10);

    // Short SDA glitch while SCL high must vanish, then a real START.
    tbSdaLow = 1'b1;
    waitCycles(FL - 1);
    tbSdaLow = 1'b0;
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 8, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 10, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, !mSda, 10, 0, 1'b0);
      else waitCycles(10);
      applyStimulus(1'b1, 1'b1, 20, 0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 10, 0, 1'b0);
    if (mSda) applyStimulus(1'b0, 1'b0, 10, 0, 1'b0);
    else waitCycles(10);
    applyStimulus(1'b1, 1'b1, 10, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 20, 0, 1'b0);

    // START, then repeated START, then idle-high without STOP.
    applyStimulus(1'b0, 1'b0, 10, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 10, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 10, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 10, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 10, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 10, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 10, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 70, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      bit isScl;
      bit gl;
      int h;
      int g;
      isScl = 1'($urandom_range(0, 1));
      gl = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 5) == 0) ? int'($urandom_range(51, 70)) : int'($urandom_range(5, 20));
      g = (h >= 15 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, FL - 1)) : 0;
      applyStimulus(isScl, isScl ? !mScl : !mSda, h, g, gl);
    end
    if (mScl) applyStimulus(1'b1, 1'b0, 10, 0, 1'b0);
    if (!mSda) applyStimulus(1'b0, 1'b1, 10, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 70, 0, 1'b0);

    // Own SDA drive: released in reset and on the first clock, seen as a START after.
    reset = 1'b0;
    sda_drive_low = 1'b1;
    mScl = 1'b1;
    mSda = 1'b1;
    mBusy = 1'b0;
    waitCycles(2);
    checkOutput("drv_in_reset", 32'(sda), 32'd1);
    reset = 1'b1;
    checkOutput("drv_first_clk", 32'(sda), 32'd1);
    waitCycles(1);
    checkOutput("drv_second_clk", 32'(sda), 32'd0);
    modelEdge(1'b0, 1'b0, 15);
    waitCycles(15);

    // Reset in the middle of a transfer.
    reset = 1'b0;
    #1;
    checkOutput("midrst_pad", 32'(sda), 32'd1);
    checkOutput("midrst_busy", 32'(bus_busy), 32'd0);
    sda_drive_low = 1'b0;
    mScl = 1'b1;
    mSda = 1'b1;
    mBusy = 1'b0;
    waitCycles(3);
    reset = 1'b1;
    waitCycles(5);
    applyStimulus(1'b0, 1'b0, 15, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 15, 0, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
    scl_hold = 1'b1;
    #1;
    checkOutput("stretch_pad_low", 32'(scl), 32'd0);
    modelEdge(1'b1, 1'b0, 20);
    waitCycles(20);
    scl_hold = 1'b0;
    #1;
    checkOutput("stretch_pad_rel", 32'(scl), 32'd1);
    modelEdge(1'b1, 1'b1, 20);
    waitCycles(20);
`else
    scl_hold = 1'b1;
    #1;
    checkOutput("nostretch_pad", 32'(scl), 32'd1);
    waitCycles(20);
    scl_hold = 1'b0;
`endif

    waitCycles(20);
    checkOutput("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
